// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - requester and memory-bus signal bundle for mem_bus_arbiter
interface mem_bus_arbiter_if #(
    parameter int ADDRW  = 8,
    parameter int DATAW  = 8,
    parameter int BURSTW = 4
);
    logic              req_aes;
    logic [ADDRW-1:0]  addr_aes;
    logic [BURSTW-1:0] len_aes;
    logic              wr_aes;
    logic [DATAW-1:0]  wdata_aes;
    logic              req_sha;
    logic [ADDRW-1:0]  addr_sha;
    logic [BURSTW-1:0] len_sha;
    logic              wr_sha;
    logic [DATAW-1:0]  wdata_sha;
    logic              grant_aes;
    logic              grant_sha;
    logic              beat_done;
    logic              burst_done;
    logic              err;
    logic              bus_valid;
    logic              bus_wr;
    logic [ADDRW-1:0]  bus_addr;
    logic [DATAW-1:0]  bus_wdata;
    logic              bus_ack;

    modport slave (
        input  req_aes, addr_aes, len_aes, wr_aes, wdata_aes,
        input  req_sha, addr_sha, len_sha, wr_sha, wdata_sha,
        input  bus_ack,
        output grant_aes, grant_sha, beat_done, burst_done, err,
        output bus_valid, bus_wr, bus_addr, bus_wdata
    );

    modport master (
        output req_aes, addr_aes, len_aes, wr_aes, wdata_aes,
        output req_sha, addr_sha, len_sha, wr_sha, wdata_sha,
        output bus_ack,
        input  grant_aes, grant_sha, beat_done, burst_done, err,
        input  bus_valid, bus_wr, bus_addr, bus_wdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin burst arbiter sharing one memory bus between AES and SHA
module mem_bus_arbiter #(
    parameter int ADDRW   = 8,
    parameter int DATAW   = 8,
    parameter int BURSTW  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_bus_arbiter_if.slave bus
);
    localparam int CNTW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

    state_t            state;
    logic              last_sha;
    logic              grant_aes_q;
    logic              grant_sha_q;
    logic              wr_q;
    logic              err_q;
    logic [ADDRW-1:0]  addr_q;
    logic [BURSTW-1:0] len_q;
    logic [BURSTW-1:0] idx;
    logic [CNTW-1:0]   wait_cnt;
    logic              busy;
    logic              last_beat;
    logic              timed_out;
    logic              pick_aes;

    assign busy      = (state == BUSY);
    assign last_beat = (idx == len_q);
    // Abort on the edge that would make the wait count reach TIMEOUT.
    assign timed_out = (wait_cnt == CNTW'(TIMEOUT - 1));
    assign pick_aes  = bus.req_aes && (!bus.req_sha || last_sha);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_sha    <= 1'b1;
            grant_aes_q <= 1'b0;
            grant_sha_q <= 1'b0;
            wr_q        <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            idx         <= '0;
            wait_cnt    <= '0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_aes || bus.req_sha) begin
                        grant_aes_q <= pick_aes;
                        grant_sha_q <= !pick_aes;
                        addr_q      <= pick_aes ? bus.addr_aes : bus.addr_sha;
                        len_q       <= pick_aes ? bus.len_aes  : bus.len_sha;
                        wr_q        <= pick_aes ? bus.wr_aes   : bus.wr_sha;
                        idx         <= '0;
                        wait_cnt    <= '0;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.bus_ack && !last_beat) begin
                        idx      <= idx + 1'b1;
                        addr_q   <= addr_q + 1'b1;
                        wait_cnt <= '0;
                    end else if (bus.bus_ack || timed_out) begin
                        // Completion and timeout both hand the bus back the same way.
                        err_q       <= !bus.bus_ack;
                        last_sha    <= grant_sha_q;
                        grant_aes_q <= 1'b0;
                        grant_sha_q <= 1'b0;
                        wr_q        <= 1'b0;
                        addr_q      <= '0;
                        idx         <= '0;
                        wait_cnt    <= '0;
                        state       <= RELEASE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant_aes  = grant_aes_q;
    assign bus.grant_sha  = grant_sha_q;
    assign bus.bus_valid  = grant_aes_q | grant_sha_q;
    assign bus.bus_wr     = wr_q;
    assign bus.bus_addr   = addr_q;
    assign bus.err        = err_q;
    // Combinational so the owner can advance wdata on the same edge the beat is taken.
    assign bus.beat_done  = busy && bus.bus_ack;
    assign bus.burst_done = busy && bus.bus_ack && last_beat;
    assign bus.bus_wdata  = grant_aes_q ? bus.wdata_aes :
                            grant_sha_q ? bus.wdata_sha : '0;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - randomized and directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
    localparam int ADDRW   = 8;
    localparam int DATAW   = 8;
    localparam int BURSTW  = 4;
    localparam int TIMEOUT = 255;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   beat_cnt = 0;
    int   burst_cnt = 0;
    int   err_cnt = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDRW(ADDRW), .DATAW(DATAW), .BURSTW(BURSTW)) bif ();

    mem_bus_arbiter #(.ADDRW(ADDRW), .DATAW(DATAW), .BURSTW(BURSTW), .TIMEOUT(TIMEOUT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bif)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level reference: who owns the bus, beats still owed, cycles waited.
    int         m_owner;    // 0 none, 1 AES, 2 SHA
    int         m_last;
    int         m_left;
    int         m_wait;
    logic [7:0] m_addr;
    logic       m_wr;
    logic       m_err;
    logic       m_release;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = 0; m_last = 2; m_left = 0; m_wait = 0;
            m_addr = 0; m_wr = 0; m_err = 0; m_release = 0;
        end else begin
            m_err = 0;
            if (m_owner != 0) begin
                if (bif.bus_ack) begin
                    m_left--;
                    m_addr++;
                    m_wait = 0;
                    if (m_left == 0) begin
                        m_last = m_owner; m_owner = 0; m_release = 1;
                    end
                end else begin
                    m_wait++;
                    if (m_wait == TIMEOUT) begin
                        m_err = 1; m_last = m_owner; m_owner = 0; m_release = 1;
                    end
                end
            end else if (m_release) begin
                m_release = 0;
            end else if (bif.req_aes || bif.req_sha) begin
                if (bif.req_aes && bif.req_sha) m_owner = (m_last == 1) ? 2 : 1;
                else                            m_owner = bif.req_aes ? 1 : 2;
                m_addr = (m_owner == 1) ? bif.addr_aes : bif.addr_sha;
                m_left = ((m_owner == 1) ? int'(bif.len_aes) : int'(bif.len_sha)) + 1;
                m_wr   = (m_owner == 1) ? bif.wr_aes : bif.wr_sha;
                m_wait = 0;
            end
        end
    end

    always @(negedge clk) begin
        logic       e_beat;
        logic [7:0] e_wdata;
        e_beat  = (m_owner != 0) && bif.bus_ack && rst_n;
        e_wdata = (m_owner == 1) ? bif.wdata_aes : (m_owner == 2) ? bif.wdata_sha : 8'h00;
        check("grant_aes",  bif.grant_aes,  m_owner == 1);
        check("grant_sha",  bif.grant_sha,  m_owner == 2);
        check("bus_valid",  bif.bus_valid,  m_owner != 0);
        check("bus_addr",   bif.bus_addr,   (m_owner != 0) ? m_addr : 8'h00);
        check("bus_wr",     bif.bus_wr,     (m_owner != 0) ? m_wr : 1'b0);
        check("bus_wdata",  bif.bus_wdata,  e_wdata);
        check("beat_done",  bif.beat_done,  e_beat);
        check("burst_done", bif.burst_done, e_beat && (m_left == 1));
        check("err",        bif.err,        m_err);
        if (bif.beat_done)  beat_cnt++;
        if (bif.burst_done) burst_cnt++;
        if (bif.err)        err_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bif.req_aes = 0; bif.addr_aes = 0; bif.len_aes = 0; bif.wr_aes = 0; bif.wdata_aes = 0;
        bif.req_sha = 0; bif.addr_sha = 0; bif.len_sha = 0; bif.wr_sha = 0; bif.wdata_sha = 0;
        bif.bus_ack = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        drive_idle();
        tick(); tick();
        rst_n = 1;
        tick();
    endtask

    logic [7:0] addrs [4];
    int         n;
    int         done_at;
    int         order [$];
    logic       prev_a;
    logic       prev_s;
    int         t_err;
    int         t_drop;
    int         t_sha;
    int         snap_beat;
    int         snap_burst;
    int         quiet;

    initial begin
        drive_idle();
        tick();
        check("reset_valid", bif.bus_valid, 0);
        check("reset_grants", {bif.grant_aes, bif.grant_sha}, 0);
        do_reset();

        // Plain AES write burst of 4 beats at 0x10
        bif.req_aes = 1; bif.addr_aes = 8'h10; bif.len_aes = 3; bif.wr_aes = 1; bif.bus_ack = 1;
        bif.wdata_aes = 8'hA5;
        tick();
        bif.req_aes = 0;
        n = 0; done_at = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bif.beat_done) begin
                if (n < 4) addrs[n] = bif.bus_addr;
                n++;
                if (bif.burst_done) done_at = n;
            end
        end
        check("tp1_beats", n, 4);
        check("tp1_done_at", done_at, 4);
        for (int i = 0; i < 4; i++) check("tp1_addr", addrs[i], 8'h10 + i);
        check("tp1_grant_low", bif.grant_aes, 0);

        // Both requesting continuously: strict alternation starting with AES
        do_reset();
        bif.req_aes = 1; bif.req_sha = 1; bif.len_aes = 0; bif.len_sha = 0;
        bif.addr_aes = 8'h20; bif.addr_sha = 8'h80; bif.bus_ack = 1;
        order.delete();
        prev_a = 0; prev_s = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bif.grant_aes && !prev_a) order.push_back(1);
            if (bif.grant_sha && !prev_s) order.push_back(2);
            prev_a = bif.grant_aes; prev_s = bif.grant_sha;
        end
        check("tp2_count_ge4", order.size() >= 4, 1);
        for (int i = 0; i < 4 && i < order.size(); i++) check("tp2_order", order[i], (i % 2 == 0) ? 1 : 2);
        tick();
        drive_idle();
        repeat (4) tick();

        // SHA burst wrapping the address space
        bif.req_sha = 1; bif.addr_sha = 8'hFE; bif.len_sha = 2; bif.bus_ack = 1;
        tick();
        bif.req_sha = 0;
        n = 0; done_at = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bif.beat_done) begin
                if (n < 3) addrs[n] = bif.bus_addr;
                n++;
                if (bif.burst_done) done_at = n;
            end
        end
        check("tp3_addr0", addrs[0], 8'hFE);
        check("tp3_addr1", addrs[1], 8'hFF);
        check("tp3_addr2", addrs[2], 8'h00);
        check("tp3_done_at", done_at, 3);

        // AES times out with SHA pending
        drive_idle();
        bif.req_aes = 1; bif.len_aes = 1; bif.addr_aes = 8'h30; bif.req_sha = 1; bif.len_sha = 0;
        tick();
        bif.req_aes = 0;
        snap_burst = burst_cnt;
        t_err = 0; t_drop = 0; t_sha = 0;
        for (int t = 1; t < 300; t++) begin
            @(negedge clk);
            if (bif.err && t_err == 0) t_err = t;
            if (!bif.grant_aes && t_drop == 0) t_drop = t;
            if (bif.grant_sha) begin t_sha = t; break; end
        end
        check("tp4_err_delay", t_err - 1, TIMEOUT);
        check("tp4_drop_with_err", t_drop, t_err);
        check("tp4_sha_after", t_sha - t_drop, 2);
        check("tp4_no_burst", burst_cnt - snap_burst, 0);
        #1;
        bif.req_sha = 0; bif.bus_ack = 1;
        repeat (4) tick();

        // Reset during the third beat of an AES burst
        bif.req_aes = 1; bif.len_aes = 5; bif.addr_aes = 8'h50; bif.req_sha = 1; bif.len_sha = 0;
        bif.bus_ack = 1;
        tick();
        bif.req_aes = 0;
        tick(); tick();
        snap_burst = burst_cnt;
        rst_n = 0;
        #1;
        check("tp5_rst_valid", bif.bus_valid, 0);
        check("tp5_rst_beat", bif.beat_done, 0);
        check("tp5_rst_addr", bif.bus_addr, 0);
        tick(); tick();
        check("tp5_no_burst", burst_cnt - snap_burst, 0);
        rst_n = 1;
        tick();
        @(negedge clk);
        check("tp5_sha_granted", bif.grant_sha, 1);
        #1;
        bif.req_sha = 0;
        repeat (4) tick();

        // Slow acks, request dropped after grant
        bif.req_aes = 1; bif.len_aes = 2; bif.addr_aes = 8'h40; bif.wr_aes = 1; bif.bus_ack = 0;
        tick();
        bif.req_aes = 0; bif.wr_aes = 0; bif.addr_aes = 8'h99; bif.len_aes = 0;
        snap_beat = beat_cnt; snap_burst = burst_cnt;
        for (int b = 0; b < 3; b++) begin
            repeat (3) tick();
            bif.bus_ack = 1;
            tick();
            bif.bus_ack = 0;
        end
        repeat (3) tick();
        check("tp6_beats", beat_cnt - snap_beat, 3);
        check("tp6_burst", burst_cnt - snap_burst, 1);

        // Random traffic against the reference model
        quiet = 0;
        snap_beat = err_cnt;
        for (int i = 0; i < 4000; i++) begin
            bif.req_aes   = ($urandom % 3) != 0;
            bif.req_sha   = ($urandom % 3) != 0;
            bif.addr_aes  = 8'($urandom);
            bif.addr_sha  = 8'($urandom);
            bif.len_aes   = 4'($urandom);
            bif.len_sha   = 4'($urandom);
            bif.wr_aes    = 1'($urandom);
            bif.wr_sha    = 1'($urandom);
            bif.wdata_aes = 8'($urandom);
            bif.wdata_sha = 8'($urandom);
            if (i == 1000 || ($urandom % 900) == 0) quiet = 280;
            if (quiet > 0) begin
                bif.bus_ack = 0;
                quiet--;
            end else begin
                bif.bus_ack = ($urandom % 4) != 0;
            end
            if (($urandom % 700) == 0) begin
                rst_n = 0;
                #2;
                rst_n = 1;
            end
            tick();
        end
        check("rand_saw_timeout", err_cnt > snap_beat, 1);

        drive_idle();
        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
